// File: rtl/pattern_scan_ctrl_pkg.sv
// pattern_scan_ctrl_pkg
// Shared types and constants for the 1011 pattern scan controller:
// controller FSM states, detector FSM states and the detected pattern.
package pattern_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } ctrl_state_t;

  // Detector states name the prefix of PATTERN already matched:
  // S0 none, S1 "1", S2 "10", S3 "101".
  typedef enum logic [1:0] {
    S0,
    S1,
    S2,
    S3
  } det_state_t;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// pattern_scan_ctrl_if
// Word stream handshake between a producer and pattern_scan_ctrl.
//   in_valid  producer word valid        (master -> slave)
//   in_data   producer word, DATA_W bits (master -> slave)
//   in_ready  controller can accept word (slave -> master)
interface pattern_scan_ctrl_if #(
  parameter int DATA_W = 8
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/pattern_scan_ctrl_seq_1011_core.sv
// seq_1011_core
// Serial 1011 detector FSM with a Mealy hit output.
//   clk, rstn  clock, asynchronous active-low reset
//   clr        synchronous return to S0 (wins over en)
//   en         advance one bit; state holds when low
//   din        serial bit
//   hit        combinational: final bit of the pattern seen this cycle
// Configuration macro: OVERLAP_DETECT_EN -- when defined, a hit leaves
// the detector in S1 so overlapping occurrences are counted; otherwise
// it restarts from S0.
module seq_1011_core
  import pattern_scan_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic hit
);

  det_state_t r_state;
  det_state_t w_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S0;
    end else if (clr) begin
      r_state <= S0;
    end else if (en) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    hit    = 1'b0;
    case (r_state)
      S0: w_next = (din == PATTERN[3]) ? S1 : S0;
      S1: w_next = (din == PATTERN[2]) ? S2 : S1;
      S2: w_next = (din == PATTERN[1]) ? S3 : S0;
      S3: begin
        if (din == PATTERN[0]) begin
          hit = en;
`ifdef OVERLAP_DETECT_EN
          w_next = S1;
`else
          w_next = S0;
`endif
        end else begin
          w_next = S2;
        end
      end
      default: w_next = S0;
    endcase
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
// Frame controller: accepts DATA_W-bit words over a valid/ready handshake,
// shifts each MSB-first into a 1011 detector one bit per cycle, and counts
// detections over a frame of frame_len words.
//   clk, rstn  clock, asynchronous active-low reset
//   start      begin a frame (IDLE only); frame_len sampled with it
//   abort      return to IDLE from any active state, no done pulse
//   in_if      slave side of the word handshake (in_ready only in LOAD)
//   det_hit    registered one-cycle pulse per detection
//   match_cnt  saturating detection count of the current/last frame
//   busy       high in LOAD, SHIFT and DONE
//   done       one-cycle pulse at normal frame end
// Configuration macro: OVERLAP_DETECT_EN (see seq_1011_core).
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8,
  parameter int LEN_W  = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [LEN_W-1:0]     frame_len,
  input  logic                 abort,
  pattern_scan_ctrl_if.slave   in_if,
  output logic                 det_hit,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 busy,
  output logic                 done
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  ctrl_state_t       r_state;
  ctrl_state_t       w_next;
  logic [DATA_W-1:0] r_shreg;
  logic [LEN_W-1:0]  r_words;
  logic [BIT_W-1:0]  r_bitidx;
  logic              r_det_hit;
  logic [CNT_W-1:0]  r_match_cnt;

  logic w_frame_start;
  logic w_accept;
  logic w_det_en;
  logic w_det_hit;

  always_comb begin
    w_next        = r_state;
    w_frame_start = 1'b0;
    w_accept      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_frame_start = 1'b1;
          w_next        = (frame_len != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        if (in_if.in_valid) begin
          w_accept = 1'b1;
          w_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (r_bitidx == LAST_BIT) begin
          w_next = (r_words != '0) ? LOAD : DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // Abort overrides everything except reset, including a word offered in LOAD.
    if (abort && (r_state != IDLE)) begin
      w_next   = IDLE;
      w_accept = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_words     <= '0;
      r_bitidx    <= '0;
      r_det_hit   <= 1'b0;
      r_match_cnt <= '0;
    end else begin
      r_state   <= w_next;
      // A hit in the cycle abort is seen still lands in det_hit/match_cnt.
      r_det_hit <= w_det_hit;
      if (w_frame_start) begin
        r_match_cnt <= '0;
        r_words     <= frame_len;
      end else if (w_det_hit && (r_match_cnt != '1)) begin
        r_match_cnt <= r_match_cnt + 1'b1;
      end
      if (w_accept) begin
        r_shreg  <= in_if.in_data;
        r_words  <= r_words - 1'b1;
        r_bitidx <= '0;
      end else if (r_state == SHIFT) begin
        r_shreg  <= r_shreg << 1;
        r_bitidx <= r_bitidx + 1'b1;
      end
    end
  end

  // Detector only advances in SHIFT, so a pattern can straddle a LOAD stall.
  assign w_det_en = (r_state == SHIFT);

  seq_1011_core u_det (
    .clk  (clk),
    .rstn (rstn),
    .clr  (w_frame_start),
    .en   (w_det_en),
    .din  (r_shreg[DATA_W-1]),
    .hit  (w_det_hit)
  );

  assign in_if.in_ready = (r_state == LOAD);
  assign busy           = (r_state != IDLE);
  assign done           = (r_state == DONE);
  assign det_hit        = r_det_hit;
  assign match_cnt      = r_match_cnt;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
`timescale 1ns/1ps
module tb_pattern_scan_ctrl;

`ifdef OVERLAP_DETECT_EN
  localparam int B6_HITS = 2;
`else
  localparam int B6_HITS = 1;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] frame_len = '0;

  logic       det_hit, busy, done;
  logic [7:0] match_cnt;
  logic       det_hit2, busy2, done2;
  logic [1:0] match_cnt2;

  pattern_scan_ctrl_if #(.DATA_W(8)) bus ();
  pattern_scan_ctrl_if #(.DATA_W(8)) bus2 ();

  // Second instance (CNT_W=2) sees the same word stream to check saturation.
  assign bus2.in_valid = bus.in_valid;
  assign bus2.in_data  = bus.in_data;

  pattern_scan_ctrl #(.DATA_W(8), .CNT_W(8), .LEN_W(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .frame_len (frame_len),
    .abort     (abort),
    .in_if     (bus.slave),
    .det_hit   (det_hit),
    .match_cnt (match_cnt),
    .busy      (busy),
    .done      (done)
  );

  pattern_scan_ctrl #(.DATA_W(8), .CNT_W(2), .LEN_W(8)) dut2 (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .frame_len (frame_len),
    .abort     (abort),
    .in_if     (bus2.slave),
    .det_hit   (det_hit2),
    .match_cnt (match_cnt2),
    .busy      (busy2),
    .done      (done2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int start_cyc;
    int lat;
    int hits;
    int cnt;
    int first_hit;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  int hit_acc = 0;
  int first_hit = -1;
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      hit_acc   = 0;
      first_hit = -1;
    end else begin
      if (det_hit) begin
        hit_acc++;
        if (first_hit < 0) first_hit = cyc;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc - e.start_cyc, e.lat);
          check("hit_pulses", hit_acc, e.hits);
          check("match_cnt", {24'd0, match_cnt}, e.cnt);
          check("match_cnt_w2", {30'd0, match_cnt2}, (e.cnt > 3) ? 3 : e.cnt);
          check("done_w2", {31'd0, done2}, 1);
          if (e.first_hit >= 0) check("first_hit_cycle", first_hit - e.start_cyc, e.first_hit);
        end
        hit_acc   = 0;
        first_hit = -1;
      end
    end
  end

  task automatic start_frame(input int n, input int lat, input int hits, input int fh);
    exp_t e;
    @(negedge clk);
    start       = 1'b1;
    frame_len   = 8'(n);
    e.start_cyc = cyc;
    e.lat       = lat;
    e.hits      = hits;
    e.cnt       = hits;
    e.first_hit = fh;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic start_only(input int n);
    @(negedge clk);
    start     = 1'b1;
    frame_len = 8'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input int gap);
    int t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check("ready_timeout", 0, 1);
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 0, 1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 0);
    check({tag, "_det_hit"}, {31'd0, det_hit}, 0);
    check({tag, "_match_cnt"}, {24'd0, match_cnt}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_match_cnt_w2"}, {30'd0, match_cnt2}, 0);
    check({tag, "_busy_w2"}, {31'd0, busy2}, 0);
  endtask

  initial begin
    logic rdy_seen;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset values
    @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;

    // Single word 0xB0: hit after 4th shift bit, done at cycle 10
    start_frame(1, 10, 1, 6);
    send_word(8'hB0, 0);
    drain();

    // 0xB6 = 1011_0110: overlap-dependent count
    start_frame(1, 10, B6_HITS, -1);
    send_word(8'hB6, 0);
    drain();

    // Pattern straddles the word boundary: 0x01, 0x60
    start_frame(2, 19, 1, 14);
    send_word(8'h01, 0);
    send_word(8'h60, 0);
    drain();

    // Same with a 5-cycle in_valid gap before word 2
    start_frame(2, 24, 1, 19);
    send_word(8'h01, 0);
    send_word(8'h60, 5);
    drain();

    // Four hits: 8-bit counter reads 4, 2-bit counter saturates at 3
    start_frame(4, 37, 4, 6);
    for (int i = 0; i < 4; i++) send_word(8'hB0, 0);
    drain();

    // frame_len=0: done next cycle, in_ready never high, start held in DONE ignored
    @(negedge clk);
    start     = 1'b1;
    frame_len = 8'd0;
    begin
      exp_t e;
      e.start_cyc = cyc;
      e.lat       = 1;
      e.hits      = 0;
      e.cnt       = 0;
      e.first_hit = -1;
      sb.push_back(e);
    end
    rdy_seen = bus.in_ready;
    @(negedge clk);
    rdy_seen = rdy_seen | bus.in_ready;
    @(negedge clk);
    start = 1'b0;
    check("len0_idle_after_done", {31'd0, busy}, 0);
    for (int i = 0; i < 4; i++) begin
      rdy_seen = rdy_seen | bus.in_ready;
      @(negedge clk);
    end
    check("len0_in_ready_seen", {31'd0, rdy_seen}, 0);
    drain();

    // Abort in the 3rd SHIFT cycle of word 1 of 3
    start_only(3);
    send_word(8'hB0, 0);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_match_cnt", {24'd0, match_cnt}, 0);
    repeat (12) @(negedge clk);
    check("abort_still_idle", {31'd0, busy}, 0);

    // Restart after abort
    start_frame(1, 10, 1, 6);
    send_word(8'hB0, 0);
    drain();

    // rstn pulse mid-SHIFT of word 2 after one hit
    start_only(2);
    send_word(8'hB0, 0);
    send_word(8'hB0, 0);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_match_cnt", {24'd0, match_cnt}, 1);
    check("pre_reset_busy", {31'd0, busy}, 1);
    rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (12) @(negedge clk);
    check("post_reset_idle", {31'd0, busy}, 0);

    // Recovery frame after reset
    start_frame(1, 10, B6_HITS, -1);
    send_word(8'hB6, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
